ex_operand_ctrl: RTL and testbench
==================================

# ex_operand_ctrl

Hazard and operand-select controller for the ID→EX boundary of the 5-stage RV32I pipeline. Tracks the destination registers of the instructions in EX, MEM and WB in its own shadow pipeline. From these it drives the EX-stage operand-2 select (register data vs sign-extended immediate), the operand-A/B forwarding selects, and load-use stall and branch-flush control. Also keeps a saturating stall-cycle counter for performance debug.

## Interface
- No parameters.
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- Id_Rs1, Id_Rs2, Id_Rd  input  5 each  register fields of the instruction in ID.
- Id_Uses_Rs1, Id_Uses_Rs2  input  1 each  instruction in ID reads that source.
- Id_Reg_Write  input  1  ID instruction writes Rd.
- Id_Mem_Read  input  1  ID instruction is a load.
- Id_Imm_Op  input  1  operand 2 is the immediate (I-type, load, store); 0 for R-type and branch.
- Ex_Branch_Taken  input  1  branch/jump resolved taken in EX this cycle.
- Mem_Busy  input  1  data memory not ready; freezes the whole pipeline.
- Ex_Read_Data_2_Sel  output  2  2'b01 = register read data 2, 2'b10 = sign-extended immediate.
- Ex_Fwd_A, Ex_Fwd_B  output  2 each  00 = regfile, 01 = EX/MEM ALU result, 10 = MEM/WB write data.
- Pc_Write, If_Id_Write  output  1 each  enables for PC and IF/ID register.
- If_Id_Flush, Id_Ex_Flush  output  1 each  insert bubble into IF/ID, ID/EX.
- Stall_Cycles  output  16  saturating count of stall cycles.

## Operation
- Shadow stages: EX {rd, rs1, rs2, uses_rs1, uses_rs2, reg_write, mem_read, sel}, MEM {rd, reg_write}, WB {rd, reg_write}. Each advances on a rising edge when Mem_Busy=0: EX←ID fields, MEM←EX, WB←MEM.
- Bubble into EX: reg_write=0, mem_read=0, rd=0, uses_*=0, sel=2'b10.
- sel loaded as Id_Imm_Op ? 2'b10 : 2'b01. Ex_Read_Data_2_Sel = EX.sel.
- Register x0 never matches any hazard or forwarding compare.
- Forwarding (FWD_EN), evaluated per source in EX:
  - 01 if MEM.reg_write, MEM.rd≠0, MEM.rd = EX.rs.
  - else 10 if WB.reg_write, WB.rd≠0, WB.rd = EX.rs.
  - else 00. MEM wins when both match.
- Load-use hazard (hz_lu): EX.mem_read, EX.rd≠0, and EX.rd matches Id_Rs1 (Id_Uses_Rs1) or Id_Rs2 (Id_Uses_Rs2).
- Priority per cycle:
  1. Mem_Busy: all enables held, no flush, shadow frozen.
  2. Ex_Branch_Taken: If_Id_Flush=1, Id_Ex_Flush=1, Pc_Write=1, bubble into EX. Any pending stall is discarded.
  3. Hazard: Pc_Write=0, If_Id_Write=0, Id_Ex_Flush=1, bubble into EX.
  4. Otherwise normal advance.
- State machine {RUN, STALL, FLUSH}, registered, records the last unfrozen cycle's action:
  - RUN→STALL on a hazard.
  - STALL→STALL while the hazard persists; STALL→RUN when it clears.
  - any→FLUSH on a taken branch; FLUSH→RUN next cycle unless another branch or hazard occurs.
  - State holds while Mem_Busy=1.
- Stall_Cycles increments by 1 on each cycle with Pc_Write=0 and Mem_Busy=0, and saturates at 16'hFFFF.

## Timing
- Reset (async): all shadow fields 0, EX.sel=2'b10, state RUN, Stall_Cycles=0.
- Outputs during reset: Ex_Fwd_A/B=00, Ex_Read_Data_2_Sel=2'b10, Pc_Write=1, If_Id_Write=1, flushes=0.
- Pc_Write, If_Id_Write, If_Id_Flush, Id_Ex_Flush: combinational, from the ID inputs and registered shadow state, valid in the same cycle.
- Ex_Fwd_A/B and Ex_Read_Data_2_Sel: combinational from registered shadow state only, valid for the whole EX cycle of the instruction.
- A load-use stall is exactly 1 cycle with FWD_EN. The dependent instruction enters EX the cycle after the load enters MEM and receives Fwd=10.
- Reset asserted mid-stall or mid-flush: returns to RUN immediately. The first post-reset edge behaves as normal advance.

## Configuration
- FWD_EN defined: forwarding as above; only load-use stalls.
- FWD_EN undefined:
  - Ex_Fwd_A/B are tied 00.
  - The hazard condition becomes: any ID source in use matches rd (≠0, reg_write=1) of EX, MEM or WB.
  - A back-to-back RAW therefore stalls 3 cycles. The regfile is not write-through, so WB also counts.

## Test plan
- R-type after R-type (x5 written, next reads rs1=x5), FWD_EN → second instruction in EX sees Ex_Fwd_A=01, no stall, Stall_Cycles=0.
- lw x6, then add reading rs2=x6 → one cycle with Pc_Write=0, Id_Ex_Flush=1, state STALL. The add then has Ex_Fwd_B=10 and Ex_Read_Data_2_Sel=01; Stall_Cycles=1.
- addi (Id_Imm_Op=1) → Ex_Read_Data_2_Sel=10; following beq (Id_Imm_Op=0) → 01.
- Load-use hazard and Ex_Branch_Taken in the same cycle → both flushes =1, Pc_Write=1, state FLUSH, Stall_Cycles unchanged.
- Mem_Busy=1 for 3 cycles during a stall → outputs held, shadow and state frozen, Stall_Cycles frozen. Resumes exactly where it was.
- FWD_EN undefined, add x7 then sub reading x7 → 3 stall cycles, Fwd always 00, Stall_Cycles=3. A write to x0 followed by a read of x0 → no stall.

Source files
------------

// File: rtl/ex_operand_ctrl.sv
// ex_operand_ctrl: ID->EX hazard detection, operand forwarding and operand-2 select for the RV32I pipeline.
// Build option FWD_EN: forward from EX/MEM and MEM/WB so that only load-use hazards stall.
module ex_operand_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Id_Rs1,
    input  logic [4:0]  Id_Rs2,
    input  logic [4:0]  Id_Rd,
    input  logic        Id_Uses_Rs1,
    input  logic        Id_Uses_Rs2,
    input  logic        Id_Reg_Write,
    input  logic        Id_Mem_Read,
    input  logic        Id_Imm_Op,
    input  logic        Ex_Branch_Taken,
    input  logic        Mem_Busy,
    output logic [1:0]  Ex_Read_Data_2_Sel,
    output logic [1:0]  Ex_Fwd_A,
    output logic [1:0]  Ex_Fwd_B,
    output logic        Pc_Write,
    output logic        If_Id_Write,
    output logic        If_Id_Flush,
    output logic        Id_Ex_Flush,
    output logic [15:0] Stall_Cycles
);

    // state | meaning
    // RUN   | last unfrozen cycle advanced normally
    // STALL | last unfrozen cycle held PC and IF/ID for a data hazard
    // FLUSH | last unfrozen cycle squashed IF/ID and ID/EX for a taken branch
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] SEL_REG = 2'b01;
    localparam logic [1:0] SEL_IMM = 2'b10;

    state_t      state;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic [1:0]  ex_sel;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        hz;
    logic        bubble;

`ifdef FWD_EN
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic        ex_mem_read;
`else
    // Without forwarding every RAW stalls, so the load flag carries no extra information.
    logic        unused_load;
    assign unused_load = Id_Mem_Read;
`endif

    function automatic logic rd_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

`ifdef FWD_EN
    assign hz = (Id_Uses_Rs1 && rd_hit(ex_mem_read, ex_rd, Id_Rs1)) ||
                (Id_Uses_Rs2 && rd_hit(ex_mem_read, ex_rd, Id_Rs2));
`else
    // The regfile is not write-through, so a writer still in WB blocks the read as well.
    assign hz = (Id_Uses_Rs1 && (rd_hit(ex_reg_write, ex_rd, Id_Rs1) ||
                                 rd_hit(mem_reg_write, mem_rd, Id_Rs1) ||
                                 rd_hit(wb_reg_write, wb_rd, Id_Rs1))) ||
                (Id_Uses_Rs2 && (rd_hit(ex_reg_write, ex_rd, Id_Rs2) ||
                                 rd_hit(mem_reg_write, mem_rd, Id_Rs2) ||
                                 rd_hit(wb_reg_write, wb_rd, Id_Rs2)));
`endif

    always_comb begin
        Pc_Write    = 1'b1;
        If_Id_Write = 1'b1;
        If_Id_Flush = 1'b0;
        Id_Ex_Flush = 1'b0;
        bubble      = 1'b0;
        if (rst) begin
            bubble = 1'b0;
        end else if (Mem_Busy) begin
            Pc_Write    = 1'b0;
            If_Id_Write = 1'b0;
        end else if (Ex_Branch_Taken) begin
            If_Id_Flush = 1'b1;
            Id_Ex_Flush = 1'b1;
            bubble      = 1'b1;
        end else if (hz) begin
            Pc_Write    = 1'b0;
            If_Id_Write = 1'b0;
            Id_Ex_Flush = 1'b1;
            bubble      = 1'b1;
        end
    end

    assign Ex_Read_Data_2_Sel = ex_sel;

`ifdef FWD_EN
    // MEM holds the younger producer, so it takes priority over WB.
    always_comb begin
        Ex_Fwd_A = FWD_RF;
        if (rd_hit(mem_reg_write, mem_rd, ex_rs1)) begin
            Ex_Fwd_A = FWD_MEM;
        end else if (rd_hit(wb_reg_write, wb_rd, ex_rs1)) begin
            Ex_Fwd_A = FWD_WB;
        end
    end

    always_comb begin
        Ex_Fwd_B = FWD_RF;
        if (rd_hit(mem_reg_write, mem_rd, ex_rs2)) begin
            Ex_Fwd_B = FWD_MEM;
        end else if (rd_hit(wb_reg_write, wb_rd, ex_rs2)) begin
            Ex_Fwd_B = FWD_WB;
        end
    end
`else
    assign Ex_Fwd_A = 2'b00;
    assign Ex_Fwd_B = 2'b00;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else if (!Mem_Busy) begin
            case (state)
                RUN:     state <= Ex_Branch_Taken ? FLUSH : (hz ? STALL : RUN);
                STALL:   state <= Ex_Branch_Taken ? FLUSH : (hz ? STALL : RUN);
                FLUSH:   state <= Ex_Branch_Taken ? FLUSH : (hz ? STALL : RUN);
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_rd         <= 5'd0;
            ex_reg_write  <= 1'b0;
            ex_sel        <= SEL_IMM;
            mem_rd        <= 5'd0;
            mem_reg_write <= 1'b0;
            wb_rd         <= 5'd0;
            wb_reg_write  <= 1'b0;
`ifdef FWD_EN
            ex_rs1        <= 5'd0;
            ex_rs2        <= 5'd0;
            ex_mem_read   <= 1'b0;
`endif
        end else if (!Mem_Busy) begin
            wb_rd         <= mem_rd;
            wb_reg_write  <= mem_reg_write;
            mem_rd        <= ex_rd;
            mem_reg_write <= ex_reg_write;
            if (bubble) begin
                ex_rd        <= 5'd0;
                ex_reg_write <= 1'b0;
                ex_sel       <= SEL_IMM;
`ifdef FWD_EN
                ex_rs1       <= 5'd0;
                ex_rs2       <= 5'd0;
                ex_mem_read  <= 1'b0;
`endif
            end else begin
                ex_rd        <= Id_Rd;
                ex_reg_write <= Id_Reg_Write;
                ex_sel       <= Id_Imm_Op ? SEL_IMM : SEL_REG;
`ifdef FWD_EN
                ex_rs1       <= Id_Rs1;
                ex_rs2       <= Id_Rs2;
                ex_mem_read  <= Id_Mem_Read;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Stall_Cycles <= 16'd0;
        end else if (!Mem_Busy && !Pc_Write && (Stall_Cycles != 16'hFFFF)) begin
            Stall_Cycles <= Stall_Cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_ex_operand_ctrl.sv
// Self-checking bench for ex_operand_ctrl: instruction-level pipeline model plus directed scenarios.
// Works with or without FWD_EN; literal expectations select their value from the build.
module tb_ex_operand_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Id_Rs1 = 5'd0, Id_Rs2 = 5'd0, Id_Rd = 5'd0;
    logic        Id_Uses_Rs1 = 1'b0, Id_Uses_Rs2 = 1'b0, Id_Reg_Write = 1'b0;
    logic        Id_Mem_Read = 1'b0, Id_Imm_Op = 1'b0;
    logic        Ex_Branch_Taken = 1'b0, Mem_Busy = 1'b0;
    logic [1:0]  Ex_Read_Data_2_Sel, Ex_Fwd_A, Ex_Fwd_B;
    logic        Pc_Write, If_Id_Write, If_Id_Flush, Id_Ex_Flush;
    logic [15:0] Stall_Cycles;

`ifdef FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    ex_operand_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .Id_Rs1             (Id_Rs1),
        .Id_Rs2             (Id_Rs2),
        .Id_Rd              (Id_Rd),
        .Id_Uses_Rs1        (Id_Uses_Rs1),
        .Id_Uses_Rs2        (Id_Uses_Rs2),
        .Id_Reg_Write       (Id_Reg_Write),
        .Id_Mem_Read        (Id_Mem_Read),
        .Id_Imm_Op          (Id_Imm_Op),
        .Ex_Branch_Taken    (Ex_Branch_Taken),
        .Mem_Busy           (Mem_Busy),
        .Ex_Read_Data_2_Sel (Ex_Read_Data_2_Sel),
        .Ex_Fwd_A           (Ex_Fwd_A),
        .Ex_Fwd_B           (Ex_Fwd_B),
        .Pc_Write           (Pc_Write),
        .If_Id_Write        (If_Id_Write),
        .If_Id_Flush        (If_Id_Flush),
        .Id_Ex_Flush        (Id_Ex_Flush),
        .Stall_Cycles       (Stall_Cycles)
    );

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       rw;
        logic       mr;
        logic       imm;
    } inst_t;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    inst_t       m_ex, m_mem, m_wb;
    int unsigned m_stalls = 0;
    bit          m_hold = 1'b0;

    function automatic inst_t mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic rw,
                                 input logic mr, input logic imm);
        inst_t i;
        i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.u1 = u1; i.u2 = u2;
        i.rw = rw; i.mr = mr; i.imm = imm;
        return i;
    endfunction

    function automatic inst_t rtype(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
        return mk(rd, a, b, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    endfunction
    function automatic inst_t itype(input logic [4:0] rd, input logic [4:0] a);
        return mk(rd, a, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    endfunction
    function automatic inst_t load(input logic [4:0] rd, input logic [4:0] a);
        return mk(rd, a, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    endfunction
    function automatic inst_t branch(input logic [4:0] a, input logic [4:0] b);
        return mk(5'd0, a, b, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic inst_t nop();
        return itype(5'd0, 5'd0);
    endfunction
    function automatic inst_t bubble_i();
        return mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    // An in-flight instruction supplies register r when it writes a non-zero rd equal to r.
    function automatic bit writes(input inst_t p, input logic [4:0] r);
        return p.rw && (p.rd != 5'd0) && (p.rd == r);
    endfunction

    function automatic bit needs_stall(input inst_t i);
        bit h1, h2;
`ifdef FWD_EN
        h1 = m_ex.mr && (m_ex.rd != 5'd0) && (m_ex.rd == i.rs1);
        h2 = m_ex.mr && (m_ex.rd != 5'd0) && (m_ex.rd == i.rs2);
`else
        h1 = writes(m_ex, i.rs1) || writes(m_mem, i.rs1) || writes(m_wb, i.rs1);
        h2 = writes(m_ex, i.rs2) || writes(m_mem, i.rs2) || writes(m_wb, i.rs2);
`endif
        return (i.u1 && h1) || (i.u2 && h2);
    endfunction

    function automatic logic [1:0] source_of(input logic [4:0] r);
        if (r == 5'd0) return 2'b00;
`ifdef FWD_EN
        if (writes(m_mem, r)) return 2'b01;
        if (writes(m_wb, r))  return 2'b10;
`endif
        return 2'b00;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        inst_t id_i;
        bit    hz, e_pc, e_ifw, e_iff, e_ief;
        id_i = mk(Id_Rd, Id_Rs1, Id_Rs2, Id_Uses_Rs1, Id_Uses_Rs2, Id_Reg_Write, Id_Mem_Read, Id_Imm_Op);
        if (rst) begin
            m_ex = bubble_i(); m_mem = bubble_i(); m_wb = bubble_i();
            m_stalls = 0;
            m_hold = 1'b0;
            chk("rst_pc_write", Pc_Write, 1);
            chk("rst_if_id_write", If_Id_Write, 1);
            chk("rst_if_id_flush", If_Id_Flush, 0);
            chk("rst_id_ex_flush", Id_Ex_Flush, 0);
            chk("rst_fwd_a", Ex_Fwd_A, 0);
            chk("rst_fwd_b", Ex_Fwd_B, 0);
            chk("rst_sel", Ex_Read_Data_2_Sel, 2'b10);
            chk("rst_stall_cycles", Stall_Cycles, 0);
        end else begin
            hz = needs_stall(id_i);
            e_pc = 1'b1; e_ifw = 1'b1; e_iff = 1'b0; e_ief = 1'b0;
            if (Mem_Busy) begin
                e_pc = 1'b0; e_ifw = 1'b0;
            end else if (Ex_Branch_Taken) begin
                e_iff = 1'b1; e_ief = 1'b1;
            end else if (hz) begin
                e_pc = 1'b0; e_ifw = 1'b0; e_ief = 1'b1;
            end
            chk("pc_write", Pc_Write, e_pc);
            chk("if_id_write", If_Id_Write, e_ifw);
            chk("if_id_flush", If_Id_Flush, e_iff);
            chk("id_ex_flush", Id_Ex_Flush, e_ief);
            chk("fwd_a", Ex_Fwd_A, source_of(m_ex.rs1));
            chk("fwd_b", Ex_Fwd_B, source_of(m_ex.rs2));
            chk("sel", Ex_Read_Data_2_Sel, m_ex.imm ? 2'b10 : 2'b01);
            chk("stall_cycles", Stall_Cycles, m_stalls);
            m_hold = !e_ifw;
            if (!Mem_Busy) begin
                if (!e_pc && m_stalls < 65535) m_stalls++;
                m_wb  = m_mem;
                m_mem = m_ex;
                m_ex  = (Ex_Branch_Taken || hz) ? bubble_i() : id_i;
            end
        end
    end

    task automatic drive(input inst_t i);
        Id_Rd = i.rd; Id_Rs1 = i.rs1; Id_Rs2 = i.rs2;
        Id_Uses_Rs1 = i.u1; Id_Uses_Rs2 = i.u2;
        Id_Reg_Write = i.rw; Id_Mem_Read = i.mr; Id_Imm_Op = i.imm;
    endtask

    // Present an instruction in ID until it is allowed to move on to EX.
    task automatic issue(input inst_t i);
        int n;
        n = 0;
        do begin
            drive(i);
            @(posedge clk);
            #1;
            n++;
        end while (m_hold && n < 8);
        chk("issue_bound", m_hold, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        Mem_Busy = 1'b1;
        Ex_Branch_Taken = 1'b1;
        drive(rtype(5'd3, 5'd3, 5'd3));
        @(posedge clk);
        #1;
        chk("lit_rst_pc", Pc_Write, 1);
        chk("lit_rst_ifw", If_Id_Write, 1);
        chk("lit_rst_flush", {If_Id_Flush, Id_Ex_Flush}, 0);
        chk("lit_rst_sel", Ex_Read_Data_2_Sel, 2'b10);
        chk("lit_rst_cnt", Stall_Cycles, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        Mem_Busy = 1'b0;
        Ex_Branch_Taken = 1'b0;

        // Back-to-back R-type RAW on rs1.
        issue(rtype(5'd5, 5'd1, 5'd2));
        issue(rtype(5'd8, 5'd5, 5'd3));
        chk("lit_raw_fwd_a", Ex_Fwd_A, FWD_ON ? 2'b01 : 2'b00);
        chk("lit_raw_sel", Ex_Read_Data_2_Sel, 2'b01);
        chk("lit_raw_cnt", Stall_Cycles, FWD_ON ? 0 : 3);
        // A write to x0 never creates a dependency.
        issue(itype(5'd0, 5'd1));
        issue(rtype(5'd9, 5'd0, 5'd0));
        chk("lit_x0_cnt", Stall_Cycles, FWD_ON ? 0 : 3);

        // Load-use on rs2.
        issue(load(5'd6, 5'd1));
        drive(rtype(5'd10, 5'd4, 5'd6));
        #1;
        chk("lit_lu_pc", Pc_Write, 0);
        chk("lit_lu_ifw", If_Id_Write, 0);
        chk("lit_lu_idex_flush", Id_Ex_Flush, 1);
        chk("lit_lu_ifid_flush", If_Id_Flush, 0);
        issue(rtype(5'd10, 5'd4, 5'd6));
        chk("lit_lu_fwd_b", Ex_Fwd_B, FWD_ON ? 2'b10 : 2'b00);
        chk("lit_lu_sel", Ex_Read_Data_2_Sel, 2'b01);
        chk("lit_lu_cnt", Stall_Cycles, FWD_ON ? 1 : 6);
        repeat (3) issue(nop());

        // Operand-2 select follows the instruction type.
        issue(itype(5'd11, 5'd1));
        chk("lit_addi_sel", Ex_Read_Data_2_Sel, 2'b10);
        issue(branch(5'd1, 5'd2));
        chk("lit_beq_sel", Ex_Read_Data_2_Sel, 2'b01);

        // Load-use and taken branch in the same cycle: the branch wins.
        issue(load(5'd12, 5'd1));
        drive(rtype(5'd17, 5'd12, 5'd3));
        Ex_Branch_Taken = 1'b1;
        #1;
        chk("lit_br_pc", Pc_Write, 1);
        chk("lit_br_flushes", {If_Id_Flush, Id_Ex_Flush}, 2'b11);
        @(posedge clk);
        #1;
        Ex_Branch_Taken = 1'b0;
        chk("lit_br_cnt", Stall_Cycles, FWD_ON ? 1 : 6);
        repeat (3) issue(nop());

        // Memory busy while a load-use hazard is pending.
        issue(load(5'd13, 5'd1));
        drive(rtype(5'd18, 5'd13, 5'd2));
        Mem_Busy = 1'b1;
        repeat (3) begin
            #1;
            chk("lit_busy_pc", Pc_Write, 0);
            chk("lit_busy_flushes", {If_Id_Flush, Id_Ex_Flush}, 0);
            chk("lit_busy_sel", Ex_Read_Data_2_Sel, 2'b10);
            chk("lit_busy_cnt", Stall_Cycles, FWD_ON ? 1 : 6);
            @(posedge clk);
            #1;
        end
        Mem_Busy = 1'b0;
        issue(rtype(5'd18, 5'd13, 5'd2));
        chk("lit_busy_fwd_a", Ex_Fwd_A, FWD_ON ? 2'b10 : 2'b00);
        chk("lit_busy_cnt_after", Stall_Cycles, FWD_ON ? 2 : 9);
        repeat (3) issue(nop());

        // Two producers of x5 in flight: the younger one (MEM) must win.
        issue(rtype(5'd5, 5'd1, 5'd2));
        issue(rtype(5'd5, 5'd3, 5'd4));
        issue(rtype(5'd19, 5'd5, 5'd5));
        chk("lit_prio_fwd", {Ex_Fwd_A, Ex_Fwd_B}, FWD_ON ? 4'b0101 : 4'b0000);
        chk("lit_prio_cnt", Stall_Cycles, FWD_ON ? 2 : 12);
        issue(nop());
        issue(rtype(5'd21, 5'd1, 5'd19));
        chk("lit_wb_fwd_b", Ex_Fwd_B, FWD_ON ? 2'b10 : 2'b00);
        chk("lit_wb_cnt", Stall_Cycles, FWD_ON ? 2 : 14);

        // Reset in the middle of a load-use stall.
        issue(load(5'd22, 5'd1));
        drive(rtype(5'd23, 5'd22, 5'd0));
        #1;
        rst = 1'b1;
        #1;
        chk("lit_midrst_pc", Pc_Write, 1);
        chk("lit_midrst_flush", Id_Ex_Flush, 0);
        chk("lit_midrst_sel", Ex_Read_Data_2_Sel, 2'b10);
        chk("lit_midrst_cnt", Stall_Cycles, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(rtype(5'd23, 5'd22, 5'd0));
        chk("lit_postrst_cnt", Stall_Cycles, 0);
        chk("lit_postrst_sel", Ex_Read_Data_2_Sel, 2'b01);
        repeat (4) issue(nop());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
